// File: rtl/cache_control.sv
// cache_control
//   Control FSM for the 2-way, 8-set, 128-bit-line LC-3b cache. Hits are
//   answered in the request cycle; a miss writes back the dirty victim (if
//   any), allocates the line from physical memory, then returns to IDLE where
//   the still-held CPU request re-evaluates as a hit.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   mem_read, mem_write     CPU request (held until mem_resp; both = write)
//   mem_address             CPU byte address
//   mem_resp                one-cycle CPU completion pulse
//   hit, dirty, victim_tag  datapath status for the addressed set
//   load_line               datapath line/tag/valid write strobe
//   sel_pmem_data           datapath data mux: 1 = pmem line, 0 = CPU-merged
//   set_dirty, clear_dirty  dirty-bit control qualified by load_line
//   lru_update              touch LRU of the accessed set
//   pmem_read, pmem_write   physical memory line request, held until pmem_resp
//   pmem_address            line-aligned physical address
//   pmem_resp               physical memory completion pulse
//
// Optional feature (macro CACHE_PERF_COUNTERS_EN)
//   hit_count, miss_count, wb_count  16-bit wrapping performance counters

module cache_control #(
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 3,
    parameter int TAG_BITS    = 9    // OFFSET_BITS+INDEX_BITS+TAG_BITS == 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [15:0]         mem_address,
    output logic                mem_resp,
    input  logic                hit,
    input  logic                dirty,
    input  logic [TAG_BITS-1:0] victim_tag,
    output logic                load_line,
    output logic                sel_pmem_data,
    output logic                set_dirty,
    output logic                clear_dirty,
    output logic                lru_update,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [15:0]         pmem_address,
    input  logic                pmem_resp
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count,
    output logic [15:0]         wb_count
`endif
);

    localparam int LINE_BITS = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t                state, state_next;
    logic [LINE_BITS-1:0]  line_q;     // held request address, line part only
    logic [TAG_BITS-1:0]   vtag_q;     // victim tag captured at miss time
    logic                  req;
    logic                  miss_start;

    // Byte offset never reaches physical memory (line-aligned transfers).
    logic unused_offset;
    assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

    assign req = mem_read | mem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            line_q <= '0;
            vtag_q <= '0;
        end else begin
            state <= state_next;
            if (miss_start) begin
                line_q <= mem_address[15:OFFSET_BITS];
                vtag_q <= victim_tag;
            end
        end
    end

    always_comb begin
        state_next    = state;
        miss_start    = 1'b0;
        mem_resp      = 1'b0;
        load_line     = 1'b0;
        sel_pmem_data = 1'b0;
        set_dirty     = 1'b0;
        clear_dirty   = 1'b0;
        lru_update    = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = '0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp   = 1'b1;
                        lru_update = 1'b1;
                        // A write (including read+write) merges CPU data into the line.
                        if (mem_write) begin
                            load_line = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end else begin
                        miss_start = 1'b1;
                        state_next = dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {vtag_q, line_q[INDEX_BITS-1:0], {OFFSET_BITS{1'b0}}};
                if (pmem_resp)
                    state_next = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {line_q, {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    load_line     = 1'b1;
                    sel_pmem_data = 1'b1;
                    clear_dirty   = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are forced low for the whole reset assertion, not just after
        // the state register clears, so a held hit cannot leak a mem_resp.
        if (reset) begin
            mem_resp      = 1'b0;
            load_line     = 1'b0;
            sel_pmem_data = 1'b0;
            set_dirty     = 1'b0;
            clear_dirty   = 1'b0;
            lru_update    = 1'b0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
            pmem_address  = '0;
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    // refill_q marks the cycle right after a fill: the hit seen then is the
    // re-check of an already-counted miss, not a new hit.
    logic refill_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refill_q   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            refill_q <= (state == ALLOCATE) && pmem_resp;
            if ((state == IDLE) && req && hit && !refill_q)
                hit_count <= hit_count + 16'd1;
            if (miss_start)
                miss_count <= miss_count + 16'd1;
            if ((state == WRITEBACK) && pmem_resp)
                wb_count <= wb_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic        mem_resp;
    logic        hit, dirty;
    logic [8:0]  victim_tag;
    logic        load_line, sel_pmem_data, set_dirty, clear_dirty, lru_update;
    logic        pmem_read, pmem_write;
    logic [15:0] pmem_address;
    logic        pmem_resp;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [15:0] hit_count, miss_count, wb_count;
`endif

    int checks = 0;
    int fails  = 0;
    // Reference event totals for the performance counters.
    int m_hits = 0;
    int m_miss = 0;
    int m_wb   = 0;

    cache_control #(
        .OFFSET_BITS(4),
        .INDEX_BITS (3),
        .TAG_BITS   (9)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_resp     (mem_resp),
        .hit          (hit),
        .dirty        (dirty),
        .victim_tag   (victim_tag),
        .load_line    (load_line),
        .sel_pmem_data(sel_pmem_data),
        .set_dirty    (set_dirty),
        .clear_dirty  (clear_dirty),
        .lru_update   (lru_update),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp)
`ifdef CACHE_PERF_COUNTERS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .wb_count     (wb_count)
`endif
    );

    always #5 clk = ~clk;

    // {mem_resp, load_line, sel_pmem_data, set_dirty, clear_dirty, lru_update,
    //  pmem_read, pmem_write, pmem_address}
    function automatic logic [23:0] pack(input logic resp, ld, sel, sd, cd, lru,
                                         pr, pw, input logic [15:0] a);
        return {resp, ld, sel, sd, cd, lru, pr, pw, a};
    endfunction

    function automatic logic [23:0] observed();
        return pack(mem_resp, load_line, sel_pmem_data, set_dirty, clear_dirty,
                    lru_update, pmem_read, pmem_write, pmem_address);
    endfunction

    // Expected outputs for a CPU request that hits in IDLE.
    function automatic logic [23:0] hit_vec(input logic is_write);
        return pack(1'b1, is_write, 1'b0, is_write, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    endfunction

    task automatic scramble();
        mem_address = 16'($urandom);
        dirty       = 1'($urandom);
        victim_tag  = 9'($urandom);
        hit         = 1'($urandom);
    endtask

    // One CPU transaction, with the bench acting as physical memory.
    // wb_lat/fill_lat: extra cycles before pmem_resp in WRITEBACK/ALLOCATE.
    task automatic run_req(input logic rd, wr, input logic [15:0] addr,
                           input logic is_hit, is_dirty, input logic [8:0] vtag,
                           input int wb_lat, fill_lat, input logic drop,
                           input string name);
        logic [23:0] obs, exp;
        logic [15:0] wb_a, fill_a;
        logic        w, last;
        w      = wr;
        wb_a   = {vtag, addr[6:4], 4'h0};
        fill_a = {addr[15:4], 4'h0};

        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = addr;
        hit = is_hit; dirty = is_dirty; victim_tag = vtag; pmem_resp = 1'b0;
        #1;
        obs = observed();
        exp = is_hit ? hit_vec(w) : 24'h0;
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s/request: got %h expected %h", name, obs, exp);
        end

        if (is_hit) begin
            m_hits++;
        end else begin
            m_miss++;
            if (is_dirty) begin
                m_wb++;
                for (int k = 0; k <= wb_lat; k++) begin
                    @(negedge clk);
                    scramble();
                    pmem_resp = (k == wb_lat);
                    #1;
                    obs = observed();
                    exp = pack(0, 0, 0, 0, 0, 0, 0, 1, wb_a);
                    checks++;
                    if (obs !== exp) begin
                        fails++;
                        $display("FAIL %s/writeback[%0d]: got %h expected %h", name, k, obs, exp);
                    end
                end
            end
            for (int k = 0; k <= fill_lat; k++) begin
                @(negedge clk);
                scramble();
                if (drop && k == 0) begin
                    mem_read = 1'b0; mem_write = 1'b0;
                end
                pmem_resp = (k == fill_lat);
                last = (k == fill_lat);
                #1;
                obs = observed();
                exp = pack(0, last, last, 0, last, 0, 1, 0, fill_a);
                checks++;
                if (obs !== exp) begin
                    fails++;
                    $display("FAIL %s/allocate[%0d]: got %h expected %h", name, k, obs, exp);
                end
            end
            // Re-check of the held request; a dropped request gets no response.
            @(negedge clk);
            pmem_resp = 1'b0; mem_address = addr; hit = !drop; dirty = 1'($urandom);
            #1;
            obs = observed();
            exp = drop ? 24'h0 : hit_vec(w);
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s/recheck: got %h expected %h", name, obs, exp);
            end
        end

        // CPU drops the request; a stray pmem_resp in IDLE must be ignored.
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        pmem_resp = 1'($urandom); hit = 1'($urandom); dirty = 1'($urandom);
        #1;
        obs = observed();
        checks++;
        if (obs !== 24'h0) begin
            fails++;
            $display("FAIL %s/idle: got %h expected %h", name, obs, 24'h0);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] obs;
        reset = 1'b1;
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h1234;
        hit = 1'b1; dirty = 1'b0; victim_tag = '0; pmem_resp = 1'b0;
        #12;
        obs = observed();
        checks++;
        if (obs !== 24'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 24'h0);
        end
        @(negedge clk);
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
`ifdef CACHE_PERF_COUNTERS_EN
        #1;
        checks++;
        if ({hit_count, miss_count, wb_count} !== 48'h0) begin
            fails++;
            $display("FAIL reset_counters: got %h expected 0", {hit_count, miss_count, wb_count});
        end
`endif
    endtask

    task automatic test_read_hit();
        run_req(1, 0, 16'h1234, 1, 0, 9'h0, 0, 0, 0, "read_hit");
    endtask

    task automatic test_clean_read_miss();
        run_req(1, 0, 16'h0456, 0, 0, 9'h1FF, 0, 4, 0, "clean_read_miss");
    endtask

    task automatic test_dirty_write_miss();
        run_req(0, 1, 16'h8A3C, 0, 1, 9'h012, 3, 2, 0, "dirty_write_miss");
    endtask

    task automatic test_read_write_hit();
        run_req(1, 1, 16'($urandom), 1, 0, 9'h0, 0, 0, 0, "read_write_hit");
    endtask

    task automatic test_dropped_request();
        run_req(1, 0, 16'hBEEF, 0, 1, 9'h0A5, 1, 2, 1, "dropped_miss");
    endtask

    task automatic test_reset_mid_allocate();
        logic [23:0] obs, exp;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h3C71;
        hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
        m_miss++;
        @(negedge clk);
        #1;
        obs = observed();
        exp = pack(0, 0, 0, 0, 0, 0, 1, 0, 16'h3C70);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL reset_mid/allocate: got %h expected %h", obs, exp);
        end
        #1 reset = 1'b1;
        #1;
        obs = observed();
        checks++;
        if (obs !== 24'h0) begin
            fails++;
            $display("FAIL reset_mid/async: got %h expected %h", obs, 24'h0);
        end
        @(negedge clk);
        reset = 1'b0; hit = 1'b1;
        #1;
        // Back in IDLE: the held request is answered as a plain hit.
        obs = observed();
        exp = hit_vec(1'b0);
        m_hits++;
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL reset_mid/idle_hit: got %h expected %h", obs, exp);
        end
        @(negedge clk);
        mem_read = 1'b0; hit = 1'b0;
    endtask

    task automatic test_random();
        logic rd, wr;
        int   kind;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            rd = (kind != 1);
            wr = (kind != 0);
            run_req(rd, wr, 16'($urandom), 1'($urandom), 1'($urandom), 9'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 5) == 0), "random");
        end
    endtask

`ifdef CACHE_PERF_COUNTERS_EN
    task automatic test_counters();
        #1;
        checks++;
        if (hit_count !== 16'(m_hits)) begin
            fails++;
            $display("FAIL hit_count: got %0d expected %0d", hit_count, m_hits);
        end
        checks++;
        if (miss_count !== 16'(m_miss)) begin
            fails++;
            $display("FAIL miss_count: got %0d expected %0d", miss_count, m_miss);
        end
        checks++;
        if (wb_count !== 16'(m_wb)) begin
            fails++;
            $display("FAIL wb_count: got %0d expected %0d", wb_count, m_wb);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_hit();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_read_write_hit();
        test_dropped_request();
`ifdef CACHE_PERF_COUNTERS_EN
        test_counters();
`endif
        test_reset_mid_allocate();
        // Reset cleared the counters; restart the reference totals from the
        // single hit observed after the release.
        m_hits = 1; m_miss = 0; m_wb = 0;
        test_random();
`ifdef CACHE_PERF_COUNTERS_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
